// File: rtl/tinycpu_w_if.sv
`default_nettype none
// ============================================================================
// tinycpu_w_if : req/ack external memory port of the tinycpu_w core
// Revision     : 1.0
// ============================================================================
interface tinycpu_w_if #(
  parameter int WIDTH = 8
) ();
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );
endinterface
`default_nettype wire

// File: rtl/tinycpu_w.sv
`default_nettype none
// ============================================================================
// tinycpu_w : parametrised accumulator CPU (A/B/M/P) with carry and req/ack bus
// Revision  : 1.0
// ============================================================================
module tinycpu_w #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        reset,
  tinycpu_w_if.master mem,
  output logic        flag_c,
  output logic        halted,
  output logic        retire
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_OR   = 4'h1,
    OP_INV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_LDI  = 4'h4,
    OP_LDM  = 4'h5,
    OP_STM  = 4'h6,
    OP_SUBH = 4'h7,
    OP_SWAB = 4'h8,
    OP_SWMB = 4'h9,
    OP_CPPA = 4'hA,
    OP_CPAM = 4'hB,
    OP_JU   = 4'hC,
    OP_JE   = 4'hD,
    OP_JL   = 4'hE,
    OP_JG   = 4'hF
  } opcode_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             c_q, c_d;
  logic [7:0]       instr_q, instr_d;

  opcode_t          op;
  logic [3:0]       imm;
  logic [WIDTH:0]   sum;
  logic             a_eq_b;
  logic             a_lt_b;
  logic             a_gt_b;
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic             retire_raw;

  assign op     = opcode_t'(instr_q[7:4]);
  assign imm    = instr_q[3:0];
  assign sum    = {1'b0, a_q} + {1'b0, b_q};
  assign a_eq_b = (a_q == b_q);
  assign a_lt_b = (a_q < b_q);
  assign a_gt_b = (a_q > b_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= RESET_PC;
      c_q     <= 1'b0;
      instr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      p_q     <= p_d;
      c_q     <= c_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    m_d        = m_q;
    p_d        = p_q;
    c_d        = c_q;
    instr_d    = instr_q;
    req        = 1'b0;
    we         = 1'b0;
    addr       = p_q;
    retire_raw = 1'b0;

    case (state_q)
      ST_FETCH: begin
        req  = 1'b1;
        addr = p_q;
        if (mem.ack) begin
          instr_d = mem.rdata[7:0];
          p_d     = p_q + 1'b1;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        retire_raw = 1'b1;
        state_d    = ST_FETCH;
        case (op)
          OP_AND:  a_d = a_q & b_q;
          OP_OR:   a_d = a_q | b_q;
          OP_INV:  a_d = ~a_q;
          OP_ADD:  {c_d, a_d} = sum;
          OP_LDI:  a_d = {a_q[WIDTH-5:0], imm};
          OP_LDM, OP_STM: begin
            retire_raw = 1'b0;
            state_d    = ST_MEM;
          end
          OP_SUBH: begin
            // imm[3] selects HLT; imm[2:0] carry no meaning for this opcode
            if (imm[3]) begin
              state_d = ST_HALT;
            end else begin
              a_d = a_q - b_q;
              c_d = a_lt_b;
            end
          end
          OP_SWAB: begin
            a_d = b_q;
            b_d = a_q;
          end
          OP_SWMB: begin
            m_d = b_q;
            b_d = m_q;
          end
          OP_CPPA: a_d = p_q;
          OP_CPAM: m_d = a_q;
          OP_JU:   p_d = m_q;
          OP_JE:   if (a_eq_b) p_d = m_q;
          OP_JL:   if (a_lt_b) p_d = m_q;
          OP_JG:   if (a_gt_b) p_d = m_q;
          default: ;
        endcase
      end

      ST_MEM: begin
        req  = 1'b1;
        addr = m_q;
        we   = (op == OP_STM);
        if (mem.ack) begin
          if (op == OP_LDM) a_d = mem.rdata;
          retire_raw = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_HALT: ;

      default: state_d = ST_FETCH;
    endcase
  end

  // Gating with reset drops the bus request asynchronously, even mid-transaction.
  assign mem.req   = req & ~reset;
  assign mem.we    = we;
  assign mem.addr  = addr;
  assign mem.wdata = a_q;
  assign flag_c    = c_q;
  assign halted    = (state_q == ST_HALT);
  assign retire    = retire_raw & ~reset;

endmodule
`default_nettype wire

// File: doc/tinycpu_w.md
Name: tinycpu_w

Overview:
- Parametrised successor to the 8-bit accumulator CPU core: same A/B/M/P register model and 4-bit opcode map, but with configurable datapath width and reset vector.
- Adds a carry flag, SUB and HLT opcodes, and a req/ack external memory port that tolerates wait states, replacing the internally instantiated SRAM.
- Sits between system memory (or an arbiter) and nothing else; it is the top-level compute engine of the tiny-CPU subsystem.

Parameters:
- WIDTH, 8, width of A/B/M/P, memory address and data buses; legal range 8..32.
- RESET_PC, 0, value loaded into P on reset; must fit in WIDTH bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory transaction request, held high until acknowledged.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  WIDTH  transaction address; stable while mem_req=1.
- mem_wdata  out  WIDTH  write data (= A); stable while mem_req=1 and mem_we=1.
- mem_rdata  in  WIDTH  read data; sampled on the cycle where mem_req and mem_ack are both 1.
- mem_ack  in  1  completes the current transaction; ignored while mem_req=0.
- flag_c  out  1  carry/borrow flag.
- halted  out  1  high once HLT has executed.
- retire  out  1  one-cycle pulse on the cycle an instruction completes.

Behaviour:
- Reset (asynchronous, reset=1):
  - A=B=M=0, P=RESET_PC, C=0, instr=0, state=FETCH.
  - mem_req=0, mem_we=0, retire=0, halted=0.
  - mem_req is forced low immediately, even mid-transaction; a pending ack is discarded.
  - After release, the first request is to address RESET_PC.
- States: FETCH, EXEC, MEM, HALT. mem_req is 1 exactly in FETCH and MEM.
- FETCH:
  - Drives mem_addr=P, mem_we=0.
  - On req&ack: instr<=mem_rdata[7:0], P<=P+1 (mod 2^WIDTH), go to EXEC.
  - Otherwise stay in FETCH.
- EXEC (one cycle): decode instr[7:4]; instr[3:0] is the immediate.
  - Opcodes:
    - 0 AND: A=A&B.
    - 1 OR: A=A|B.
    - 2 INV: A=~A.
    - 3 ADD: {C,A}=A+B (WIDTH+1-bit sum).
    - 4 LDI: A={A[WIDTH-5:0],imm}.
    - 5 LDM and 6 STM: go to MEM.
    - 7: imm[3]=0 is SUB: A=A-B, C=1 iff A<B before the op (borrow); imm[3]=1 is HLT.
    - 8 SWAB: A<->B.
    - 9 SWMB: M<->B.
    - A CPPA: A=P (already incremented).
    - B CPAM: M=A.
    - C JU: P=M.
    - D JE: P=M if A==B.
    - E JL: P=M if A<B.
    - F JG: P=M if A>B.
  - Comparisons are unsigned, full WIDTH.
  - Only ADD and SUB modify C.
  - Non-memory, non-HLT ops: retire=1 this cycle, next state FETCH.
  - HLT: retire=1, next state HALT.
- MEM:
  - Drives mem_addr=M; mem_we=1 for STM, 0 for LDM; mem_wdata=A.
  - On req&ack: LDM loads A<=mem_rdata, retire=1, go to FETCH.
  - Otherwise hold all outputs stable.
- HALT: halted=1, no further requests; exit only via reset.
- Latency with mem_ack tied high:
  - Non-memory instruction: 2 cycles.
  - LDM/STM: 3 cycles.
  - Each ack wait cycle adds 1.
- Boundaries:
  - P wraps from 2^WIDTH-1 to 0 on fetch.
  - A jump to the current P is legal (tight loop).
  - LDI with WIDTH=8 reproduces the 8-bit shift-in behaviour.
  - Ack asserted on the same cycle req first rises completes in that cycle.
  - Unused instr bits 2:0 of opcode 7 are ignored.

Test Plan:
- WIDTH=8, RESET_PC=0x10, ack tied 1; program LDI 3, LDI 4, HLT -> A=0x34, retire at cycles 2, 4, 6 after reset release, halted=1, mem_req stays 0 thereafter.
- WIDTH=16; A=0xFFFF, B=0x0001, ADD -> A=0x0000, C=1; then SUB with A=0, B=1 -> A=0xFFFF, C=1; AND -> C unchanged.
- Ack delayed 3 cycles on every transaction; STM with M=0x20, A=0x5A -> mem_addr/mem_we/mem_wdata held constant for 4 req cycles, single write of 0x5A to 0x20; LDM from 0x20 returns A=0x5A.
- JL with A=2, B=5, M=0x40 -> next fetch address 0x40; JG with the same values -> fetch P+1; JE with A==B -> jump taken.
- P=0xFF (WIDTH=8), fetch CPPA -> A=0x00, next fetch at 0x00.
- Reset asserted while mem_req=1 and ack low in MEM -> mem_req falls without a clock edge; after release, registers are at reset values and the first fetch address is RESET_PC.
